// File: rtl/mochila_bank_arbiter.sv
// N-master by N_BANKS RAM crossbar: per-bank round-robin grant, 1-cycle response,
// decode-error responses, per-bank power-gate drain handshake and contention counters.
module mochila_bank_arbiter #(
    parameter int          NMASTERS    = 4,
    parameter int          N_BANKS     = 2,
    parameter int          BANK_WORDS  = 8192,
    parameter bit          INTERLEAVED = 1'b0,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] ERR_RDATA   = 32'hBADCAB1E
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NMASTERS-1:0]                    m_req_i,
    input  logic [NMASTERS-1:0]                    m_we_i,
    input  logic [NMASTERS*4-1:0]                  m_be_i,
    input  logic [NMASTERS*32-1:0]                 m_addr_i,
    input  logic [NMASTERS*32-1:0]                 m_wdata_i,
    output logic [NMASTERS-1:0]                    m_gnt_o,
    output logic [NMASTERS-1:0]                    m_rvalid_o,
    output logic [NMASTERS*32-1:0]                 m_rdata_o,
    output logic [NMASTERS-1:0]                    m_err_o,
    output logic [N_BANKS-1:0]                     b_req_o,
    output logic [N_BANKS-1:0]                     b_we_o,
    output logic [N_BANKS*4-1:0]                   b_be_o,
    output logic [N_BANKS*$clog2(BANK_WORDS)-1:0]  b_addr_o,
    output logic [N_BANKS*32-1:0]                  b_wdata_o,
    input  logic [N_BANKS*32-1:0]                  b_rdata_i,
    input  logic [N_BANKS-1:0]                     pwrgate_req_i,
    output logic [N_BANKS-1:0]                     pwrgate_ack_o,
    input  logic                                   cnt_clr_i,
    output logic [N_BANKS*CNT_W-1:0]               conflict_cnt_o
);
    localparam int BW   = $clog2(BANK_WORDS);
    localparam int NB   = $clog2(N_BANKS);
    localparam int BI_W = (N_BANKS > 1) ? NB : 1;
    localparam int MI_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam logic [32:0]     LIMIT     = 33'(longint'(N_BANKS) * longint'(BANK_WORDS) * 64'd4);
    localparam logic [BI_W-1:0] BANK_MASK = BI_W'(N_BANKS - 1);

    typedef enum logic [1:0] {ACTIVE, DRAIN, GATED} pg_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [NMASTERS-1:0] dec_err;
    logic [BI_W-1:0]     dec_bank  [NMASTERS];
    logic [BW-1:0]       dec_local [NMASTERS];

    logic [N_BANKS-1:0]  bank_open, win_vld, busy, inflight;
    logic [MI_W-1:0]     win_idx [N_BANKS];
    logic [MI_W-1:0]     rr_ptr  [N_BANKS];
    pg_state_t           pg_state [N_BANKS];
    logic [CNT_W-1:0]    cnt [N_BANKS];

    logic [NMASTERS-1:0] vld_p1, err_p1, we_p1;
    logic [BI_W-1:0]     bank_p1 [NMASTERS];

    // Address decode; the word offset drops addr[1:0]
    always_comb begin
        for (int m = 0; m < NMASTERS; m++) begin
            dec_err[m]   = {1'b0, m_addr_i[m*32 +: 32]} >= LIMIT;
            dec_bank[m]  = BI_W'(m_addr_i[m*32+2 +: 30] >> (INTERLEAVED ? 0 : BW)) & BANK_MASK;
            dec_local[m] = BW'(m_addr_i[m*32+2 +: 30] >> (INTERLEAVED ? NB : 0));
        end
    end

    // Per-bank round-robin pick; decode errors bypass the banks entirely
    always_comb begin
        int idx;
        int n_cand;
        int w;
        idx       = 0;
        n_cand    = 0;
        w         = 0;
        m_gnt_o   = '0;
        b_req_o   = '0;
        b_we_o    = '0;
        b_be_o    = '0;
        b_addr_o  = '0;
        b_wdata_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_open[b] = !rst_i && (pg_state[b] == ACTIVE) && !pwrgate_req_i[b];
            win_vld[b]   = 1'b0;
            win_idx[b]   = '0;
            n_cand       = 0;
            for (int k = 0; k < NMASTERS; k++) begin
                idx = (int'(rr_ptr[b]) + k) % NMASTERS;
                if (m_req_i[idx] && !dec_err[idx] && dec_bank[idx] == BI_W'(b)) begin
                    n_cand++;
                    if (!win_vld[b]) begin
                        win_vld[b] = 1'b1;
                        win_idx[b] = MI_W'(idx);
                    end
                end
            end
            busy[b] = (n_cand >= 2);
            if (win_vld[b] && bank_open[b]) begin
                w                      = int'(win_idx[b]);
                m_gnt_o[w]             = 1'b1;
                b_req_o[b]             = 1'b1;
                b_we_o[b]              = m_we_i[w];
                b_be_o[b*4 +: 4]       = m_be_i[w*4 +: 4];
                b_addr_o[b*BW +: BW]   = dec_local[w];
                b_wdata_o[b*32 +: 32]  = m_wdata_i[w*32 +: 32];
            end
        end
        for (int m = 0; m < NMASTERS; m++) begin
            if (!rst_i && m_req_i[m] && dec_err[m]) begin
                m_gnt_o[m] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            inflight[b] = 1'b0;
            for (int m = 0; m < NMASTERS; m++) begin
                if (vld_p1[m] && !err_p1[m] && bank_p1[m] == BI_W'(b)) begin
                    inflight[b] = 1'b1;
                end
            end
            conflict_cnt_o[b*CNT_W +: CNT_W] = cnt[b];
        end
    end

    // Stage p1: response registers and per-bank control state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= '0;
            for (int b = 0; b < N_BANKS; b++) begin
                rr_ptr[b]        <= '0;
                pg_state[b]      <= ACTIVE;
                pwrgate_ack_o[b] <= 1'b0;
                cnt[b]           <= '0;
            end
        end else begin
            vld_p1 <= m_gnt_o;
            for (int b = 0; b < N_BANKS; b++) begin
                if (b_req_o[b]) begin
                    rr_ptr[b] <= MI_W'((int'(win_idx[b]) + 1) % NMASTERS);
                end
                case (pg_state[b])
                    ACTIVE: if (pwrgate_req_i[b]) pg_state[b] <= DRAIN;
                    DRAIN: begin
                        if (!pwrgate_req_i[b]) begin
                            pg_state[b] <= ACTIVE;
                        end else if (!inflight[b]) begin
                            pg_state[b]      <= GATED;
                            pwrgate_ack_o[b] <= 1'b1;
                        end
                    end
                    GATED: begin
                        if (!pwrgate_req_i[b]) begin
                            pg_state[b]      <= ACTIVE;
                            pwrgate_ack_o[b] <= 1'b0;
                        end
                    end
                    default: pg_state[b] <= ACTIVE;
                endcase
                if (cnt_clr_i) begin
                    cnt[b] <= '0;
                end else if (busy[b]) begin
                    cnt[b] <= sat_inc(cnt[b]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        err_p1 <= dec_err;
        we_p1  <= m_we_i;
        for (int m = 0; m < NMASTERS; m++) begin
            bank_p1[m] <= dec_bank[m];
        end
    end

    always_comb begin
        for (int m = 0; m < NMASTERS; m++) begin
            m_rvalid_o[m]         = vld_p1[m];
            m_err_o[m]            = vld_p1[m] & err_p1[m];
            m_rdata_o[m*32 +: 32] = '0;
            if (vld_p1[m]) begin
                if (err_p1[m]) begin
                    m_rdata_o[m*32 +: 32] = ERR_RDATA;
                end else if (!we_p1[m]) begin
                    m_rdata_o[m*32 +: 32] = b_rdata_i[int'(bank_p1[m])*32 +: 32];
                end
            end
        end
    end
endmodule

// File: tb/tb_mochila_bank_arbiter.sv
// Bench for mochila_bank_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the arbiter rules.
module tb_mochila_bank_arbiter;
    localparam int NM  = 4;
    localparam int NBK = 2;
    localparam int BWD = 8192;
    localparam int AW  = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NM-1:0]      m_req = '0, m_we = '0;
    logic [NM*4-1:0]    m_be = '0;
    logic [NM*32-1:0]   m_addr = '0, m_wdata = '0;
    logic [NBK*32-1:0]  b_rdata = '0;
    logic [NBK-1:0]     pwrgate = '0;
    logic               cnt_clr = 1'b0;

    logic [NM-1:0]      gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [NM*32-1:0]   rdata0, rdata1;
    logic [NBK-1:0]     b_req0, b_we0, ack0, b_req1, b_we1, ack1;
    logic [NBK*4-1:0]   b_be0, b_be1;
    logic [NBK*AW-1:0]  b_addr0, b_addr1;
    logic [NBK*32-1:0]  b_wdata0, b_wdata1;
    logic [NBK*16-1:0]  cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mochila_bank_arbiter #(.NMASTERS(NM), .N_BANKS(NBK), .BANK_WORDS(BWD), .INTERLEAVED(1'b0))
    dut (
        .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_gnt_o(gnt0), .m_rvalid_o(rvalid0),
        .m_rdata_o(rdata0), .m_err_o(err0), .b_req_o(b_req0), .b_we_o(b_we0),
        .b_be_o(b_be0), .b_addr_o(b_addr0), .b_wdata_o(b_wdata0), .b_rdata_i(b_rdata),
        .pwrgate_req_i(pwrgate), .pwrgate_ack_o(ack0), .cnt_clr_i(cnt_clr),
        .conflict_cnt_o(cnt0)
    );

    mochila_bank_arbiter #(.NMASTERS(NM), .N_BANKS(NBK), .BANK_WORDS(BWD), .INTERLEAVED(1'b1))
    dut_il (
        .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_gnt_o(gnt1), .m_rvalid_o(rvalid1),
        .m_rdata_o(rdata1), .m_err_o(err1), .b_req_o(b_req1), .b_we_o(b_we1),
        .b_be_o(b_be1), .b_addr_o(b_addr1), .b_wdata_o(b_wdata1), .b_rdata_i(b_rdata),
        .pwrgate_req_i(pwrgate), .pwrgate_ack_o(ack1), .cnt_clr_i(cnt_clr),
        .conflict_cnt_o(cnt1)
    );

    // Reference model of the contiguous-mapped instance
    int rr[NBK];
    int pst[NBK];              // 0 active, 1 draining, 2 gated
    bit pack[NBK];
    int cnt[NBK];
    bit mv[NM], merr[NM], mwe[NM];
    int mbank[NM];
    bit e_gnt[NM], e_derr[NM], e_open[NBK];
    int e_bank[NM], e_local[NM], e_win[NBK], e_ncand[NBK];

    task automatic model_eval();
        logic [31:0] a;
        int unsigned word;
        int m;
        for (int i = 0; i < NM; i++) begin
            a          = m_addr[i*32 +: 32];
            e_derr[i]  = longint'(a) >= longint'(NBK * BWD * 4);
            word       = a / 4;
            e_bank[i]  = int'((word / BWD) % NBK);
            e_local[i] = int'(word % BWD);
        end
        for (int b = 0; b < NBK; b++) begin
            e_open[b]  = !rst && pst[b] == 0 && !pwrgate[b];
            e_win[b]   = -1;
            e_ncand[b] = 0;
            for (int k = 0; k < NM; k++) begin
                m = (rr[b] + k) % NM;
                if (m_req[m] && !e_derr[m] && e_bank[m] == b) begin
                    e_ncand[b]++;
                    if (e_win[b] < 0) e_win[b] = m;
                end
            end
        end
        for (int i = 0; i < NM; i++)
            e_gnt[i] = !rst && m_req[i] &&
                       (e_derr[i] || (e_open[e_bank[i]] && e_win[e_bank[i]] == i));
    endtask

    always @(posedge clk) begin
        bit infl;
        model_eval();
        if (rst) begin
            for (int b = 0; b < NBK; b++) begin
                rr[b] = 0; pst[b] = 0; pack[b] = 0; cnt[b] = 0;
            end
            for (int i = 0; i < NM; i++) mv[i] = 0;
        end else begin
            for (int b = 0; b < NBK; b++) begin
                infl = 0;
                for (int i = 0; i < NM; i++)
                    if (mv[i] && !merr[i] && mbank[i] == b) infl = 1;
                if (pst[b] == 0) begin
                    if (pwrgate[b]) pst[b] = 1;
                end else if (pst[b] == 1) begin
                    if (!pwrgate[b]) pst[b] = 0;
                    else if (!infl) begin pst[b] = 2; pack[b] = 1; end
                end else if (!pwrgate[b]) begin
                    pst[b] = 0; pack[b] = 0;
                end
                if (e_win[b] >= 0 && e_open[b]) rr[b] = (e_win[b] + 1) % NM;
                if (cnt_clr) cnt[b] = 0;
                else if (e_ncand[b] >= 2 && cnt[b] < 65535) cnt[b]++;
            end
            for (int i = 0; i < NM; i++) begin
                mv[i] = e_gnt[i]; merr[i] = e_derr[i]; mwe[i] = m_we[i]; mbank[i] = e_bank[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
        pwrgate = '0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_master(input int m, input logic we, input logic [31:0] addr);
        m_req[m] = 1'b1;
        m_we[m]  = we;
        m_be[m*4 +: 4] = 4'hF;
        m_addr[m*32 +: 32] = addr;
        m_wdata[m*32 +: 32] = $urandom;
    endtask

    task automatic test_reset();
        idle();
        for (int m = 0; m < NM; m++) set_master(m, 1'b0, 32'(m * 4));
        rst = 1'b1;
        @(negedge clk);
        checks++; if (gnt0 !== '0) begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt0); end
        checks++; if (b_req0 !== '0) begin errors++; $display("FAIL reset_breq got %b exp 0", b_req0); end
        tick();
        @(negedge clk);
        checks++; if (rvalid0 !== '0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid0); end
        checks++; if (rdata0 !== '0 || err0 !== '0) begin errors++; $display("FAIL reset_rdata got %h/%b exp 0", rdata0, err0); end
        checks++; if (ack0 !== '0 || cnt0 !== '0) begin errors++; $display("FAIL reset_ack_cnt got %b/%h exp 0", ack0, cnt0); end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_rotation();
        logic [NM-1:0] exp_rv;
        do_reset();
        for (int m = 0; m < NM; m++) set_master(m, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            exp_rv = (i == 0) ? '0 : NM'(1 << ((i - 1) % NM));
            @(negedge clk);
            checks++; if (gnt0 !== NM'(1 << (i % NM))) begin errors++; $display("FAIL rot_gnt%0d got %b exp %b", i, gnt0, NM'(1 << (i % NM))); end
            checks++; if (rvalid0 !== exp_rv) begin errors++; $display("FAIL rot_rvalid%0d got %b exp %b", i, rvalid0, exp_rv); end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (rvalid0 !== 4'b1000) begin errors++; $display("FAIL rot_last_rvalid got %b exp 1000", rvalid0); end
        checks++; if (cnt0[15:0] !== 16'd8) begin errors++; $display("FAIL rot_cnt0 got %0d exp 8", cnt0[15:0]); end
        checks++; if (cnt0[31:16] !== 16'd0) begin errors++; $display("FAIL rot_cnt1 got %0d exp 0", cnt0[31:16]); end
        tick();
    endtask

    task automatic test_interleaved();
        idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_master(0, 1'b0, 32'h0);
        set_master(1, 1'b0, 32'h4);
        @(negedge clk);
        checks++; if (gnt1 !== 4'b0011) begin errors++; $display("FAIL il_gnt got %b exp 0011", gnt1); end
        checks++; if (b_req1 !== 2'b11) begin errors++; $display("FAIL il_breq got %b exp 11", b_req1); end
        checks++; if (b_addr1 !== '0) begin errors++; $display("FAIL il_baddr got %h exp 0", b_addr1); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (rvalid1 !== 4'b0011) begin errors++; $display("FAIL il_rvalid got %b exp 0011", rvalid1); end
        checks++; if (cnt1 !== '0) begin errors++; $display("FAIL il_cnt got %h exp 0", cnt1); end
        tick();
    endtask

    task automatic test_decode_err();
        idle();
        set_master(2, 1'b1, 32'h0001_0000);
        @(negedge clk);
        checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL derr_gnt got %b exp 0100", gnt0); end
        checks++; if (b_req0 !== 2'b00) begin errors++; $display("FAIL derr_breq got %b exp 00", b_req0); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (rvalid0 !== 4'b0100 || err0 !== 4'b0100) begin errors++; $display("FAIL derr_resp got %b/%b exp 0100/0100", rvalid0, err0); end
        checks++; if (rdata0[95:64] !== 32'hBADCAB1E) begin errors++; $display("FAIL derr_rdata got %h exp badcab1e", rdata0[95:64]); end
        tick();
    endtask

    task automatic test_pwrgate();
        do_reset();
        set_master(0, 1'b0, 32'h0000_8000);
        @(negedge clk);
        checks++; if (gnt0 !== 4'b0001 || b_req0 !== 2'b10) begin errors++; $display("FAIL pg_first got %b/%b exp 0001/10", gnt0, b_req0); end
        tick();
        idle();
        set_master(1, 1'b0, 32'h0000_8004);
        pwrgate = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (gnt0 !== '0) begin errors++; $display("FAIL pg_stall%0d got %b exp 0", i, gnt0); end
            checks++; if (ack0 !== ((i == 2) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL pg_ack%0d got %b exp %b", i, ack0, (i == 2) ? 2'b10 : 2'b00); end
            tick();
        end
        pwrgate = 2'b00;
        @(negedge clk);
        checks++; if (ack0 !== 2'b10 || gnt0 !== '0) begin errors++; $display("FAIL pg_release got %b/%b exp 10/0000", ack0, gnt0); end
        tick();
        @(negedge clk);
        checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL pg_ack_drop got %b exp 00", ack0); end
        checks++; if (gnt0 !== 4'b0010 || b_req0 !== 2'b10) begin errors++; $display("FAIL pg_resume got %b/%b exp 0010/10", gnt0, b_req0); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_counter_sat();
        idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        pwrgate = 2'b01;
        for (int m = 0; m < NM; m++) set_master(m, 1'b0, 32'h0);
        for (int i = 0; i < 65534; i++) tick();
        @(negedge clk);
        checks++; if (cnt0[15:0] !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %h exp fffe", cnt0[15:0]); end
        checks++; if (gnt0 !== '0) begin errors++; $display("FAIL sat_gated_gnt got %b exp 0", gnt0); end
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        checks++; if (cnt0[15:0] !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %h exp ffff", cnt0[15:0]); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        checks++; if (cnt0 !== '0) begin errors++; $display("FAIL sat_clr got %h exp 0", cnt0); end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_master(0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL rstf_gnt got %b exp 0001", gnt0); end
        tick();
        set_master(1, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (gnt0 !== '0 || b_req0 !== '0) begin errors++; $display("FAIL rstf_forced got %b/%b exp 0/0", gnt0, b_req0); end
        tick();
        rst = 1'b0;
        for (int m = 0; m < NM; m++) set_master(m, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (rvalid0 !== '0 || rdata0 !== '0 || err0 !== '0) begin errors++; $display("FAIL rstf_drop got %b/%h/%b exp 0", rvalid0, rdata0, err0); end
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL rstf_restart got %b exp 0001", gnt0); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        logic        exp_breq;
        int          w;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < NM; m++) begin
                m_req[m] = ($urandom % 4) != 0;
                m_we[m]  = $urandom % 2;
                m_be[m*4 +: 4] = 4'($urandom);
                m_wdata[m*32 +: 32] = $urandom;
                if ($urandom % 10 == 0)
                    m_addr[m*32 +: 32] = ($urandom % 2) ? 32'hFFFF_FFFC : 32'h0001_0000 + 32'(($urandom % 16) * 4);
                else
                    m_addr[m*32 +: 32] = 32'(($urandom % 2) * 32'h8000 + ($urandom % 4) * 4 + $urandom % 4);
            end
            for (int b = 0; b < NBK; b++)
                if ($urandom % 16 == 0) pwrgate[b] = ~pwrgate[b];
            b_rdata = {$urandom, $urandom};
            cnt_clr = ($urandom % 20) == 0;
            rst     = ($urandom % 60) == 0;
            @(negedge clk);
            model_eval();
            for (int m = 0; m < NM; m++) begin
                exp_rd = !mv[m] ? 32'h0 : merr[m] ? 32'hBADCAB1E : mwe[m] ? 32'h0 : b_rdata[mbank[m]*32 +: 32];
                checks++; if (gnt0[m] !== e_gnt[m]) begin errors++; $display("FAIL rnd_gnt c%0d m%0d got %b exp %b", c, m, gnt0[m], e_gnt[m]); end
                checks++; if (rvalid0[m] !== mv[m] || err0[m] !== (mv[m] & merr[m])) begin errors++; $display("FAIL rnd_resp c%0d m%0d got %b/%b exp %b/%b", c, m, rvalid0[m], err0[m], mv[m], mv[m] & merr[m]); end
                checks++; if (rdata0[m*32 +: 32] !== exp_rd) begin errors++; $display("FAIL rnd_rdata c%0d m%0d got %h exp %h", c, m, rdata0[m*32 +: 32], exp_rd); end
            end
            for (int b = 0; b < NBK; b++) begin
                exp_breq = e_win[b] >= 0 && e_open[b];
                checks++; if (b_req0[b] !== exp_breq) begin errors++; $display("FAIL rnd_breq c%0d b%0d got %b exp %b", c, b, b_req0[b], exp_breq); end
                if (exp_breq) begin
                    w = e_win[b];
                    checks++;
                    if (b_addr0[b*AW +: AW] !== AW'(e_local[w]) || b_we0[b] !== m_we[w] ||
                        b_be0[b*4 +: 4] !== m_be[w*4 +: 4] || b_wdata0[b*32 +: 32] !== m_wdata[w*32 +: 32]) begin
                        errors++;
                        $display("FAIL rnd_bfields c%0d b%0d got %h/%b/%h/%h exp master %0d", c, b,
                                 b_addr0[b*AW +: AW], b_we0[b], b_be0[b*4 +: 4], b_wdata0[b*32 +: 32], w);
                    end
                end
                checks++; if (ack0[b] !== pack[b]) begin errors++; $display("FAIL rnd_ack c%0d b%0d got %b exp %b", c, b, ack0[b], pack[b]); end
                checks++; if (cnt0[b*16 +: 16] !== 16'(cnt[b])) begin errors++; $display("FAIL rnd_cnt c%0d b%0d got %0d exp %0d", c, b, cnt0[b*16 +: 16], cnt[b]); end
            end
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        tick();
        test_reset();
        test_rotation();
        test_interleaved();
        test_decode_err();
        test_pwrgate();
        test_counter_sat();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
